rtc_init_sequencer: RTL and testbench
=====================================

Name: rtc_init_sequencer

Overview:
- Upstream controller for the RTC bus write-cycle stage.
- After power-up, or on request, it walks a fixed table of NUM_ENTRIES register address/data pairs and sends each pair to the write stage.
- Each write is one handshake: a one-cycle start pulse (also used as the write stage's counter reset), then a wait for that stage's sticky completion flag.
- A per-write timeout is enforced; it reports busy/done/error to the top-level controller.

Parameters:
- NUM_ENTRIES, 4, number of table entries sent per run (1..16).
- TIMEOUT_CYCLES, 64, maximum cycles allowed in WAIT for one write before an error.
- Table contents (fixed localparam ROM, index 0..3): (0x0A,0x20), (0x0B,0x86), (0x00,0x00), (0x0B,0x06).

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  level; sampled in IDLE, DONE or ERROR to begin a run
- wr_done  in  1  completion flag from write stage (sticky high once the write finishes)
- wr_start  out  1  one-cycle pulse; resets the write stage counter and starts its cycle
- wr_addr  out  8  register address for the current entry
- wr_data  out  8  data byte for the current entry; bit 0 maps to write stage input a, bit 7 to h
- entry_idx  out  4  index of the entry in progress
- busy  out  1  high from LOAD through NEXT
- done  out  1  high in DONE
- error  out  1  high in ERROR

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - wr_start=0, wr_addr=0, wr_data=0, entry_idx=0, busy=0, done=0, error=0.
  - Timeout counter=0; wr_done history register=1. This blocks a false edge while the sticky flag is already high.
- All outputs are registered.
- wr_done is edge-detected against its own value from the previous cycle. Only a 0->1 transition counts as completion.
- States:
  - IDLE: if start=1, go to LOAD next cycle with entry_idx=0.
  - LOAD: latch table[entry_idx] into wr_addr/wr_data; busy=1; next state ISSUE.
  - ISSUE: wr_start=1 for exactly this cycle; timeout counter cleared; next state WAIT.
  - WAIT:
    - Increment the timeout counter every cycle.
    - On a wr_done rising edge, go to NEXT.
    - Otherwise, when the counter reaches TIMEOUT_CYCLES-1, go to ERROR.
    - If the edge and the timeout occur in the same cycle, the edge wins and the next state is NEXT.
  - NEXT:
    - If entry_idx==NUM_ENTRIES-1, go to DONE.
    - Otherwise entry_idx+=1 and go to LOAD.
  - DONE:
    - done=1, busy=0; wr_addr/wr_data hold the last entry.
    - If start=1, clear done and go to LOAD with entry_idx=0.
    - There is no wrap: a start still held high at the end of a run restarts the run.
  - ERROR:
    - error=1, busy=0; entry_idx holds the failing entry.
    - If start=1, clear error and go to LOAD with entry_idx=0.
  - Unused state encodings go to IDLE next cycle with all outputs at reset values.
- wr_addr/wr_data are stable from LOAD through the end of WAIT. They must not change while the write stage is active.
- Timing:
  - Minimum per-entry latency: LOAD + ISSUE + N wait cycles + NEXT = N+3 cycles.
  - wr_start never asserts twice without an intervening LOAD.
- wr_done high in the ISSUE cycle (stale sticky flag) is not an edge. The edge detector requires it to fall (the counter reset clears it downstream) and then rise again.
- start is ignored while busy=1.
- Reset mid-run abandons the write immediately. wr_start is forced to 0 and the sequencer returns to IDLE.
- entry_idx arithmetic is 4-bit unsigned and never exceeds NUM_ENTRIES-1.

Test Plan:
- Reset, start=1 for one cycle, model write stage raising wr_done 27 cycles after each wr_start:
  - four wr_start pulses with (addr,data)=(0x0A,0x20),(0x0B,0x86),(0x00,0x00),(0x0B,0x06) in order.
  - done=1 after the 4th completion; busy=0; error=0.
- Hold wr_done=1 from reset throughout, start=1:
  - no completion is accepted.
  - error=1 exactly TIMEOUT_CYCLES (64) cycles after the first wr_start; entry_idx=0.
- Model stage completes entries 0 and 1, then never responds on entry 2:
  - error=1 with entry_idx=2.
  - A new start gives wr_start with wr_addr=0x0A and entry_idx=0.
- wr_done edge arriving on WAIT cycle 63 (timeout cycle):
  - next state NEXT, no error, entry_idx increments.
- Assert reset=0 for one cycle in the middle of WAIT on entry 1:
  - all outputs go to 0 asynchronously (within the same cycle).
  - After release, no wr_start occurs until start=1.
- Pulse start while busy=1 at entry 2:
  - ignored; sequence completes normally with exactly 4 wr_start pulses total.

Source files
------------

// File: rtl/rtc_init_sequencer.sv
// RTC register initialisation sequencer.
// Walks a fixed table of address/data pairs and hands each one to the RTC
// bus write-cycle stage. Each write is a one-cycle start pulse followed by
// a wait for the rising edge of the stage's sticky completion flag. The
// wait is bounded, and on expiry the failing entry is reported.
module rtc_init_sequencer #(
   parameter int NUM_ENTRIES    = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       wr_done,
   output logic       wr_start,
   output logic [7:0] wr_addr,
   output logic [7:0] wr_data,
   output logic [3:0] entry_idx,
   output logic       busy,
   output logic       done,
   output logic       error
);

   localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0]      IDX_LAST = 4'(NUM_ENTRIES - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_ISSUE = 3'd2,
      S_WAIT  = 3'd3,
      S_NEXT  = 3'd4,
      S_DONE  = 3'd5,
      S_ERROR = 3'd6
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] tmo_cnt;
   logic [CNT_W-1:0] cnt_next;
   logic             done_q;
   logic             done_edge;

   // Register table: {address, data}; data bit 0 drives write-stage input a.
   function automatic logic [15:0] table_entry(input logic [3:0] idx);
      case (idx)
         4'd0:    table_entry = 16'h0A20;
         4'd1:    table_entry = 16'h0B86;
         4'd2:    table_entry = 16'h0000;
         4'd3:    table_entry = 16'h0B06;
         default: table_entry = 16'h0000;
      endcase
   endfunction

   // Only a fresh 0->1 of the sticky flag counts; a flag left high from the
   // previous write must first be cleared by the stage's counter reset.
   assign done_edge = wr_done & ~done_q;
   assign cnt_next  = tmo_cnt + CNT_W'(1);

   // Sequencer state machine with all outputs registered.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         wr_start  <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         entry_idx <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         error     <= 1'b0;
         tmo_cnt   <= '0;
         done_q    <= 1'b1;
      end else begin
         done_q   <= wr_done;
         wr_start <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state     <= S_LOAD;
                  entry_idx <= '0;
                  busy      <= 1'b1;
               end
            end
            S_LOAD: begin
               {wr_addr, wr_data} <= table_entry(entry_idx);
               wr_start           <= 1'b1;
               state              <= S_ISSUE;
            end
            S_ISSUE: begin
               tmo_cnt <= '0;
               state   <= S_WAIT;
            end
            S_WAIT: begin
               tmo_cnt <= cnt_next;
               // A completion in the final allowed cycle still counts.
               if (done_edge) begin
                  state <= S_NEXT;
               end else if (cnt_next == CNT_LAST) begin
                  state <= S_ERROR;
                  busy  <= 1'b0;
                  error <= 1'b1;
               end
            end
            S_NEXT: begin
               if (entry_idx == IDX_LAST) begin
                  state <= S_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  entry_idx <= entry_idx + 4'd1;
                  state     <= S_LOAD;
               end
            end
            S_DONE, S_ERROR: begin
               if (start) begin
                  state     <= S_LOAD;
                  entry_idx <= '0;
                  busy      <= 1'b1;
                  done      <= 1'b0;
                  error     <= 1'b0;
               end
            end
            default: begin
               state     <= S_IDLE;
               wr_start  <= 1'b0;
               wr_addr   <= '0;
               wr_data   <= '0;
               entry_idx <= '0;
               busy      <= 1'b0;
               done      <= 1'b0;
               error     <= 1'b0;
               tmo_cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rtc_init_sequencer.sv
// Self-checking bench for rtc_init_sequencer: a behavioural model of the
// sequencer timeline, a model of the write stage, directed scenarios and a
// randomized soak.
module tb_rtc_init_sequencer;

   localparam int NUM_ENTRIES    = 4;
   localparam int TIMEOUT_CYCLES = 64;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic       wr_done = 1'b0;
   logic       wr_start;
   logic [7:0] wr_addr;
   logic [7:0] wr_data;
   logic [3:0] entry_idx;
   logic       busy;
   logic       done;
   logic       error;

   rtc_init_sequencer #(
      .NUM_ENTRIES   (NUM_ENTRIES),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .wr_done  (wr_done),
      .wr_start (wr_start),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .entry_idx(entry_idx),
      .busy     (busy),
      .done     (done),
      .error    (error)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   logic [7:0] tbl_addr [4] = '{8'h0A, 8'h0B, 8'h00, 8'h0B};
   logic [7:0] tbl_data [4] = '{8'h20, 8'h86, 8'h00, 8'h06};

   // Model: run flag, outcome (0 none, 1 done, 2 error), entry, cycle within
   // the entry (0 load, 1 start pulse, >=2 waiting), and the pending advance.
   bit         m_run;
   int         m_fin;
   int         m_idx;
   int         m_t;
   bit         m_next;
   logic [7:0] m_addr;
   logic [7:0] m_data;
   logic       m_prev;

   // Write-stage model.
   bit  resp_en   = 1'b1;
   bit  rand_mode = 1'b0;
   int  resp_default = 27;
   int  resp_cnt  = 0;
   bit  stale_drop = 1'b0;
   int  plan[$];

   int         ws_count = 0;
   logic [7:0] ws_addr_log[$];
   logic [7:0] ws_data_log[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_run  = 1'b0;
      m_fin  = 0;
      m_idx  = 0;
      m_t    = 0;
      m_next = 1'b0;
      m_addr = 8'h00;
      m_data = 8'h00;
      m_prev = 1'b1;
   endtask

   // Advance the model by one clock using the inputs the DUT will sample.
   task automatic model_step();
      bit rise;
      rise = (wr_done === 1'b1) && (m_prev !== 1'b1);
      if (!m_run) begin
         if (start) begin
            m_run  = 1'b1;
            m_fin  = 0;
            m_idx  = 0;
            m_t    = 0;
            m_next = 1'b0;
         end
      end else if (m_next) begin
         m_next = 1'b0;
         if (m_idx == NUM_ENTRIES - 1) begin
            m_run = 1'b0;
            m_fin = 1;
         end else begin
            m_idx++;
            m_t = 0;
         end
      end else if (m_t == 0) begin
         m_addr = tbl_addr[m_idx];
         m_data = tbl_data[m_idx];
         m_t    = 1;
      end else if (m_t == 1) begin
         m_t = 2;
      end else begin
         // m_t-1 is the number of cycles since the start pulse.
         if (rise) begin
            m_next = 1'b1;
         end else if (m_t - 1 == TIMEOUT_CYCLES - 1) begin
            m_run = 1'b0;
            m_fin = 2;
         end
         m_t++;
      end
      m_prev = wr_done;
   endtask

   task automatic pick_delay(output int d);
      int r;
      r = $urandom % 10;
      if (r == 0)      d = -1;
      else if (r == 1) d = 63;
      else if (r == 2) d = 64;
      else if (r == 3) d = 62;
      else             d = 1 + ($urandom % 40);
   endtask

   // Write stage: a start pulse clears the sticky flag, which rises d cycles later.
   task automatic respond();
      int d;
      if (!resp_en) return;
      if (wr_start === 1'b1) begin
         if (plan.size() > 0)  d = plan.pop_front();
         else if (rand_mode)   pick_delay(d);
         else                  d = resp_default;
         if (rand_mode && wr_done && d >= 3 && ($urandom % 4 == 0)) stale_drop = 1'b1;
         else wr_done = 1'b0;
         resp_cnt = d;
      end else begin
         if (stale_drop) begin
            wr_done    = 1'b0;
            stale_drop = 1'b0;
         end
         if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) wr_done = 1'b1;
         end
      end
   endtask

   task automatic compare();
      chk("wr_start",  wr_start,  m_run && !m_next && m_t == 1);
      chk("wr_addr",   wr_addr,   m_addr);
      chk("wr_data",   wr_data,   m_data);
      chk("entry_idx", entry_idx, m_idx);
      chk("busy",      busy,      m_run);
      chk("done",      done,      m_fin == 1);
      chk("error",     error,     m_fin == 2);
      if (wr_start === 1'b1) begin
         ws_count++;
         ws_addr_log.push_back(wr_addr);
         ws_data_log.push_back(wr_data);
      end
   endtask

   task automatic cycle();
      respond();
      model_step();
      @(negedge clk);
      cyc++;
      compare();
   endtask

   // Reset asserted mid-cycle; outputs must clear without waiting for a clock edge.
   task automatic do_reset();
      start = 1'b0;
      reset = 1'b0;
      #1;
      chk("rst_wr_start",  wr_start,  0);
      chk("rst_wr_addr",   wr_addr,   0);
      chk("rst_wr_data",   wr_data,   0);
      chk("rst_entry_idx", entry_idx, 0);
      chk("rst_busy",      busy,      0);
      chk("rst_done",      done,      0);
      chk("rst_error",     error,     0);
      model_reset();
      resp_cnt   = 0;
      stale_drop = 1'b0;
      plan.delete();
      @(posedge clk);
      @(negedge clk);
      cyc++;
      reset = 1'b1;
      compare();
   endtask

   task automatic pulse_start();
      start = 1'b1;
      cycle();
      start = 1'b0;
   endtask

   task automatic run_to_end(input int budget);
      int n;
      n = 0;
      while (!(done === 1'b1 || error === 1'b1) && n < budget) begin
         cycle();
         n++;
      end
      if (n >= budget) begin
         n_checks++;
         n_fail++;
         $display("FAIL run_timeout: no done/error within %0d cycles (cycle %0d)", budget, cyc);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int s0, c0, ws_cyc, err_cyc, n;
      model_reset();
      @(negedge clk);
      do_reset();

      // Full run with a 27-cycle write stage.
      resp_default = 27;
      wr_done = 1'b0;
      ws_count = 0;
      ws_addr_log.delete();
      ws_data_log.delete();
      pulse_start();
      s0 = cyc;
      run_to_end(400);
      chk("t1_done_latency", cyc - s0, 120);
      chk("t1_pulses", ws_count, 4);
      chk("t1_addr0", ws_addr_log[0], 8'h0A);
      chk("t1_data0", ws_data_log[0], 8'h20);
      chk("t1_addr1", ws_addr_log[1], 8'h0B);
      chk("t1_data1", ws_data_log[1], 8'h86);
      chk("t1_addr2", ws_addr_log[2], 8'h00);
      chk("t1_data2", ws_data_log[2], 8'h00);
      chk("t1_addr3", ws_addr_log[3], 8'h0B);
      chk("t1_data3", ws_data_log[3], 8'h06);
      chk("t1_done", done, 1);
      chk("t1_busy", busy, 0);
      chk("t1_error", error, 0);

      // Completion flag stuck high: no edge, timeout on entry 0.
      do_reset();
      resp_en = 1'b0;
      wr_done = 1'b1;
      c0 = ws_count;
      ws_cyc = -1;
      err_cyc = -1;
      pulse_start();
      n = 0;
      while (error !== 1'b1 && n < 200) begin
         cycle();
         n++;
         if (wr_start === 1'b1 && ws_cyc < 0) ws_cyc = cyc;
         if (error === 1'b1) err_cyc = cyc;
      end
      chk("t2_err_delay", err_cyc - ws_cyc, 64);
      chk("t2_entry_idx", entry_idx, 0);
      chk("t2_pulses", ws_count - c0, 1);
      resp_en = 1'b1;

      // Entry 2 never answers; restart afterwards.
      do_reset();
      wr_done = 1'b0;
      plan = '{5, 9, -1};
      pulse_start();
      run_to_end(400);
      chk("t3_error", error, 1);
      chk("t3_entry_idx", entry_idx, 2);
      chk("t3_done", done, 0);
      resp_default = 10;
      pulse_start();
      cycle();
      chk("t3_restart_ws", wr_start, 1);
      chk("t3_restart_addr", wr_addr, 8'h0A);
      chk("t3_restart_idx", entry_idx, 0);
      run_to_end(400);
      chk("t3_done_after", done, 1);

      // Completion edge in the last allowed wait cycle.
      do_reset();
      wr_done = 1'b0;
      plan = '{63, 4, 4, 4};
      ws_cyc = -1;
      pulse_start();
      n = 0;
      while (!(done === 1'b1 || error === 1'b1) && n < 400) begin
         cycle();
         n++;
         if (wr_start === 1'b1 && ws_cyc < 0) ws_cyc = cyc;
         if (ws_cyc >= 0 && cyc == ws_cyc + 65) begin
            chk("t4_entry_idx", entry_idx, 1);
            chk("t4_busy", busy, 1);
            chk("t4_error", error, 0);
         end
      end
      chk("t4_done", done, 1);
      chk("t4_no_error", error, 0);

      // Reset in the middle of entry 1's wait.
      do_reset();
      wr_done = 1'b0;
      resp_default = 27;
      pulse_start();
      repeat (44) cycle();
      chk("t5_pre_idx", entry_idx, 1);
      chk("t5_pre_busy", busy, 1);
      do_reset();
      c0 = ws_count;
      repeat (20) cycle();
      chk("t5_no_pulse", ws_count - c0, 0);
      chk("t5_idle_busy", busy, 0);
      pulse_start();
      run_to_end(400);
      chk("t5_done", done, 1);

      // Start pulsed while busy on entry 2 is ignored.
      do_reset();
      wr_done = 1'b0;
      resp_default = 12;
      c0 = ws_count;
      pulse_start();
      n = 0;
      while (entry_idx !== 4'd2 && n < 300) begin
         cycle();
         n++;
      end
      chk("t6_reached_idx2", entry_idx, 2);
      pulse_start();
      run_to_end(400);
      chk("t6_pulses", ws_count - c0, 4);
      chk("t6_done", done, 1);

      // Randomized soak: random starts, write latencies, stale flags, resets.
      do_reset();
      rand_mode = 1'b1;
      wr_done = 1'b0;
      repeat (4000) begin
         if ($urandom % 800 == 0) begin
            do_reset();
         end else begin
            start = ($urandom % 16 == 0);
            cycle();
         end
      end
      start = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
